// File: rtl/spi_globals_pkg.sv
// spi_globals_pkg: shared SPI sizing, master FSM states and config bundle.
// Holds NO_OF_SLAVES, DATA_WIDTH, spi_master_state_e, spi_master_cfg_s.
package spi_globals_pkg;

  localparam int NO_OF_SLAVES = 1;
  localparam int DATA_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_master_state_e;

  typedef struct packed {
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic [7:0] baud_div;
    logic [7:0] c2t_delay;
    logic [7:0] t2c_delay;
  } spi_master_cfg_s;

  // A programmed delay of 0 behaves as 1.
  function automatic logic [7:0] min1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: sclk register plus leading/trailing/last edge strobes.
// In: pclk, areset, en, idle, cpol, baud_div, baud_cnt, edge_cnt. Out: sclk, lead_pulse, trail_pulse, last_edge.
module spi_sclk_gen #(
  parameter int EW    = 5,
  parameter int NEDGE = 16
) (
  input  logic          pclk,
  input  logic          areset,
  input  logic          en,
  input  logic          idle,
  input  logic          cpol,
  input  logic [7:0]    baud_div,
  input  logic [7:0]    baud_cnt,
  input  logic [EW-1:0] edge_cnt,
  output logic          sclk,
  output logic          lead_pulse,
  output logic          trail_pulse,
  output logic          last_edge
);

  logic tick;

  assign tick        = en && (baud_cnt == baud_div);
  // Even edge indices move away from cpol.
  assign lead_pulse  = tick && !edge_cnt[0];
  assign trail_pulse = tick && edge_cnt[0];
  assign last_edge   = tick && (edge_cnt == EW'(NEDGE - 1));

  always_ff @(posedge pclk) begin
    if (!areset) begin
      sclk <= 1'b0;
    end else if (idle) begin
      sclk <= cpol;
    end else if (tick) begin
      sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master engine, all CPOL/CPHA modes, baud and CS delays.
// In: pclk, areset, start, cpol, cpha, lsb_first, baud_div, c2t/t2c_delay, slave_sel, tx_data, miso0. Out: busy, done, rx_data, sclk, cs, mosi0.
module spi_master_ctrl
  import spi_globals_pkg::*;
#(
  parameter int NO_OF_SLAVES = spi_globals_pkg::NO_OF_SLAVES,
  parameter int DATA_WIDTH   = spi_globals_pkg::DATA_WIDTH,
  localparam int SW = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    lsb_first,
  input  logic [7:0]              baud_div,
  input  logic [7:0]              c2t_delay,
  input  logic [7:0]              t2c_delay,
  input  logic [SW-1:0]           slave_sel,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    sclk,
  output logic [NO_OF_SLAVES-1:0] cs,
  output logic                    mosi0,
  input  logic                    miso0
);

  localparam int NEDGE = 2 * DATA_WIDTH;
  localparam int EW    = $clog2(NEDGE + 1);
  localparam int BW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  spi_master_state_e state, state_next;
  spi_master_cfg_s   cfg;

  logic [SW-1:0]           sel_q;
  logic [DATA_WIDTH-1:0]   tx_q;
  logic [DATA_WIDTH-1:0]   rx_sh;
  logic [NO_OF_SLAVES-1:0] cs_lo;
  logic [7:0]              dly_cnt;
  logic [7:0]              baud_cnt;
  logic [EW-1:0]           edge_cnt;
  logic [BW-1:0]           bit_k;
  logic [BW-1:0]           shift_k;
  logic accept, dly_end, active;
  logic idle, xfer_en, gen_cpol;
  logic lead_pulse, trail_pulse, last_edge;
  logic shift_pulse, sample_pulse;

  function automatic logic [BW-1:0] bit_pos(
    input logic          lsb,
    input logic [BW-1:0] k
  );
    return lsb ? k : BW'(DATA_WIDTH - 1) - k;
  endfunction

  assign idle     = (state == IDLE);
  assign xfer_en  = (state == XFER);
  assign gen_cpol = idle ? cpol : cfg.cpol;
  assign accept   = idle && start && (32'(slave_sel) < NO_OF_SLAVES);

  // Cycles spent in SETUP/HOLD; SETUP counts one extra cycle for cs to fall.
  always_comb begin
    dly_end = 1'b0;
    if (state == SETUP) begin
      dly_end = (dly_cnt == min1(cfg.c2t_delay));
    end else if (state == HOLD) begin
      dly_end = (dly_cnt == min1(cfg.t2c_delay) - 8'd1);
    end
  end

  always_ff @(posedge pclk) begin
    if (!areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = SETUP;
      SETUP:   if (dly_end)   state_next = XFER;
      XFER:    if (last_edge) state_next = HOLD;
      HOLD:    if (dly_end)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/cs cover SETUP..HOLD but drop on the edge that returns to IDLE.
  assign active = !idle && (state_next != IDLE);

  always_comb begin
    cs_lo = '1;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (sel_q == SW'(i)) cs_lo[i] = 1'b0;
    end
  end

  spi_sclk_gen #(
    .EW    (EW),
    .NEDGE (NEDGE)
  ) u_sclk (
    .pclk        (pclk),
    .areset      (areset),
    .en          (xfer_en),
    .idle        (idle),
    .cpol        (gen_cpol),
    .baud_div    (cfg.baud_div),
    .baud_cnt    (baud_cnt),
    .edge_cnt    (edge_cnt),
    .sclk        (sclk),
    .lead_pulse  (lead_pulse),
    .trail_pulse (trail_pulse),
    .last_edge   (last_edge)
  );

  // cpha=0 already shows bit 0 from SETUP, so its final trailing edge is idle.
  assign bit_k        = edge_cnt[BW:1];
  assign shift_k      = cfg.cpha ? bit_k : bit_k + BW'(1);
  assign shift_pulse  = cfg.cpha ? lead_pulse : (trail_pulse && !last_edge);
  assign sample_pulse = cfg.cpha ? trail_pulse : lead_pulse;

  always_ff @(posedge pclk) begin
    if (!areset) begin
      cfg      <= '0;
      sel_q    <= '0;
      tx_q     <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      dly_cnt  <= '0;
      baud_cnt <= '0;
      edge_cnt <= '0;
      cs       <= '1;
      mosi0    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= active;
      cs   <= active ? cs_lo : '1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cfg.cpol      <= cpol;
            cfg.cpha      <= cpha;
            cfg.lsb_first <= lsb_first;
            cfg.baud_div  <= baud_div;
            cfg.c2t_delay <= c2t_delay;
            cfg.t2c_delay <= t2c_delay;
            sel_q         <= slave_sel;
            tx_q          <= tx_data;
            rx_sh         <= '0;
            dly_cnt       <= '0;
          end
        end
        SETUP: begin
          baud_cnt <= '0;
          edge_cnt <= '0;
          dly_cnt  <= dly_cnt + 8'd1;
          if (!cfg.cpha) begin
            mosi0 <= tx_q[bit_pos(cfg.lsb_first, '0)];
          end
        end
        XFER: begin
          if (lead_pulse || trail_pulse) begin
            baud_cnt <= '0;
            edge_cnt <= edge_cnt + EW'(1);
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
          if (shift_pulse) begin
            mosi0 <= tx_q[bit_pos(cfg.lsb_first, shift_k)];
          end
          if (sample_pulse) begin
            rx_sh[bit_pos(cfg.lsb_first, bit_k)] <= miso0;
          end
          if (last_edge) dly_cnt <= '0;
        end
        HOLD: begin
          if (dly_end) begin
            done    <= 1'b1;
            rx_data <= rx_sh;
          end else begin
            dly_cnt <= dly_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: scoreboard bench for spi_master_ctrl with a slave model.
// Expected mosi bits are queued at stimulus time and popped on sample edges.
module tb_spi_master_ctrl;

  logic       pclk = 1'b0;
  logic       areset = 1'b0;
  logic       start = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic [7:0] baud_div = 8'd1;
  logic [7:0] c2t_delay = 8'd1;
  logic [7:0] t2c_delay = 8'd1;
  logic [0:0] slave_sel = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sclk;
  logic [0:0] cs;
  logic       mosi0;
  logic       miso0 = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic exp_q[$];
  logic cur_cpol = 1'b0;
  logic cur_cpha = 1'b0;
  logic slave_lsb = 1'b0;
  logic [7:0] slave_word = 8'h00;
  logic aborting = 1'b0;

  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;
  int m_edges = 0;
  int n_fall = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  always #5 pclk = ~pclk;

  spi_master_ctrl #(
    .NO_OF_SLAVES (1),
    .DATA_WIDTH   (8)
  ) dut (
    .pclk      (pclk),
    .areset    (areset),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .baud_div  (baud_div),
    .c2t_delay (c2t_delay),
    .t2c_delay (t2c_delay),
    .slave_sel (slave_sel),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .sclk      (sclk),
    .cs        (cs),
    .mosi0     (mosi0),
    .miso0     (miso0)
  );

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic logic sbit(input int k);
    logic [7:0] w;
    w = slave_word;
    return slave_lsb ? w[k] : w[7-k];
  endfunction

  // Slave model and mosi scoreboard, evaluated just after each pclk edge.
  always @(posedge pclk) begin
    logic b;
    logic lead;
    #1;
    if (prev_cs === 1'b1 && cs[0] === 1'b0) begin
      n_fall++;
      fall_cyc = cyc;
      m_edges = 0;
      compared++;
      if (sclk !== cur_cpol) begin
        mismatched++;
        $display("FAIL idle_sclk_before_cs: got %b expected %b", sclk, cur_cpol);
      end
      if (!cur_cpha) miso0 = sbit(0);
    end else if (cs[0] === 1'b0 && sclk !== prev_sclk) begin
      m_edges++;
      last_cyc = cyc;
      if (m_edges == 1) first_cyc = cyc;
      lead = (m_edges % 2) == 1;
      if (cur_cpha ? !lead : lead) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL mosi_extra_bit: got %b expected none", mosi0);
        end else begin
          b = exp_q.pop_front();
          if (mosi0 !== b) begin
            mismatched++;
            $display("FAIL mosi_bit%0d: got %b expected %b", (m_edges - 1) / 2, mosi0, b);
          end
        end
      end
      if (cur_cpha && lead) miso0 = sbit(m_edges / 2);
      if (!cur_cpha && !lead && m_edges < 16) miso0 = sbit(m_edges / 2);
    end
    if (prev_cs === 1'b0 && cs[0] === 1'b1) begin
      rise_cyc = cyc;
      if (!aborting) begin
        compared++;
        if (sclk !== cur_cpol || m_edges != 16) begin
          mismatched++;
          $display("FAIL cs_rise: sclk %b edges %0d expected sclk %b edges 16", sclk, m_edges, cur_cpol);
        end
      end
    end
    prev_cs = cs[0];
    prev_sclk = sclk;
  end

  task automatic run_xfer(
    input  logic       pol,
    input  logic       pha,
    input  logic       lsb,
    input  logic [7:0] bd,
    input  logic [7:0] c2,
    input  logic [7:0] t2,
    input  logic [7:0] tx,
    input  logic [7:0] sw,
    output int         lat
  );
    cur_cpol = pol;
    cur_cpha = pha;
    slave_lsb = lsb;
    slave_word = sw;
    for (int k = 0; k < 8; k++) exp_q.push_back(lsb ? tx[k] : tx[7-k]);
    @(negedge pclk);
    cpol = pol; cpha = pha; lsb_first = lsb;
    baud_div = bd; c2t_delay = c2; t2c_delay = t2;
    tx_data = tx; slave_sel = 1'b0; start = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 4000; i++) begin
      @(posedge pclk);
      #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    areset = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    compared++;
    if (cs !== 1'b1) begin mismatched++; $display("FAIL reset_cs: got %b expected 1", cs); end
    compared++;
    if (sclk !== 1'b0) begin mismatched++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    compared++;
    if (mosi0 !== 1'b0) begin mismatched++; $display("FAIL reset_mosi: got %b expected 0", mosi0); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", done); end
    compared++;
    if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_rx: got %h expected 00", rx_data); end
    @(negedge pclk);
    areset = 1'b1;
    repeat (2) @(posedge pclk);
  endtask

  task automatic test_mode0;
    int lat;
    run_xfer(1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 8'd1, 8'hA5, 8'h3C, lat);
    compared++;
    if (lat != 35) begin mismatched++; $display("FAIL mode0_latency: got %0d expected 35", lat); end
    compared++;
    if (rx_data !== 8'h3C) begin mismatched++; $display("FAIL mode0_rx: got %h expected 3c", rx_data); end
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL mode0_bits_left: got %0d expected 0", exp_q.size()); end
    @(posedge pclk);
    #1;
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL mode0_done_pulse: got %b expected 0", done); end
    compared++;
    if (rx_data !== 8'h3C) begin mismatched++; $display("FAIL mode0_rx_hold: got %h expected 3c", rx_data); end
  endtask

  task automatic test_modes;
    int lat;
    logic [7:0] sw;
    logic [1:0] m;
    for (int i = 1; i < 4; i++) begin
      m = 2'(i);
      sw = 8'h4B + 8'(i * 37);
      @(negedge pclk);
      cpol = m[1];
      repeat (2) @(posedge pclk);
      #1;
      compared++;
      if (sclk !== m[1]) begin mismatched++; $display("FAIL mode%0d_idle_sclk: got %b expected %b", i, sclk, m[1]); end
      run_xfer(m[1], m[0], 1'b1, 8'd1, 8'd1, 8'd1, 8'h96, sw, lat);
      compared++;
      if (lat != 35) begin mismatched++; $display("FAIL mode%0d_latency: got %0d expected 35", i, lat); end
      compared++;
      if (rx_data !== sw) begin mismatched++; $display("FAIL mode%0d_rx: got %h expected %h", i, rx_data, sw); end
      compared++;
      if (exp_q.size() != 0) begin mismatched++; $display("FAIL mode%0d_bits_left: got %0d expected 0", i, exp_q.size()); end
    end
  endtask

  task automatic test_delays;
    int lat;
    run_xfer(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd5, 8'h6D, 8'hE1, lat);
    compared++;
    if (lat != 23) begin mismatched++; $display("FAIL delay_latency: got %0d expected 23", lat); end
    compared++;
    if (first_cyc - fall_cyc != 2) begin mismatched++; $display("FAIL cs_to_edge_gap: got %0d expected 2", first_cyc - fall_cyc); end
    compared++;
    if (rise_cyc - last_cyc != 5) begin mismatched++; $display("FAIL edge_to_cs_gap: got %0d expected 5", rise_cyc - last_cyc); end
    compared++;
    if (last_cyc - first_cyc != 15) begin mismatched++; $display("FAIL sclk_half_period_span: got %0d expected 15", last_cyc - first_cyc); end
    compared++;
    if (rx_data !== 8'hE1) begin mismatched++; $display("FAIL delay_rx: got %h expected e1", rx_data); end
  endtask

  task automatic test_back_to_back;
    int n0;
    bit seen;
    n0 = n_fall;
    cur_cpol = 1'b0; cur_cpha = 1'b0; slave_lsb = 1'b0; slave_word = 8'hC3;
    for (int k = 0; k < 8; k++) exp_q.push_back(k == 0 || k == 7);
    @(negedge pclk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    baud_div = 8'd1; c2t_delay = 8'd1; t2c_delay = 8'd1;
    tx_data = 8'h81; slave_sel = 1'b0; start = 1'b1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge pclk);
      #1;
      if (done === 1'b1) begin seen = 1; break; end
    end
    compared++;
    if (!seen) begin mismatched++; $display("FAIL b2b_first_done: got timeout expected done"); end
    compared++;
    if (rx_data !== 8'hC3) begin mismatched++; $display("FAIL b2b_rx1: got %h expected c3", rx_data); end
    tx_data = 8'h7E;
    slave_word = 8'h18;
    for (int k = 0; k < 8; k++) exp_q.push_back(k != 0 && k != 7);
    @(posedge pclk);
    #1;
    compared++;
    if (busy !== 1'b0 || cs !== 1'b1) begin mismatched++; $display("FAIL b2b_gap: busy %b cs %b expected busy 0 cs 1", busy, cs); end
    @(negedge pclk);
    start = 1'b0;
    @(posedge pclk);
    #1;
    compared++;
    if (busy !== 1'b1 || cs !== 1'b0) begin mismatched++; $display("FAIL b2b_second_accept: busy %b cs %b expected busy 1 cs 0", busy, cs); end
    compared++;
    if (fall_cyc - rise_cyc != 2) begin mismatched++; $display("FAIL b2b_cs_high_cycles: got %0d expected 2", fall_cyc - rise_cyc); end
    repeat (4) begin
      @(negedge pclk); start = 1'b1;
      @(negedge pclk); start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge pclk);
      #1;
      if (done === 1'b1) begin seen = 1; break; end
    end
    compared++;
    if (!seen || rx_data !== 8'h18) begin mismatched++; $display("FAIL b2b_rx2: got %h expected 18", rx_data); end
    repeat (10) @(posedge pclk);
    #1;
    compared++;
    if (n_fall - n0 != 2) begin mismatched++; $display("FAIL b2b_transfer_count: got %0d expected 2", n_fall - n0); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL b2b_bits_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_out_of_range;
    int n0;
    n0 = n_fall;
    @(negedge pclk);
    slave_sel = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk);
      #1;
      compared++;
      if (busy !== 1'b0 || cs !== 1'b1) begin
        mismatched++;
        $display("FAIL oor_cycle%0d: busy %b cs %b expected busy 0 cs 1", i, busy, cs);
      end
    end
    @(negedge pclk);
    start = 1'b0;
    slave_sel = 1'b0;
    compared++;
    if (n_fall != n0) begin mismatched++; $display("FAIL oor_transfers: got %0d expected 0", n_fall - n0); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit found;
    bit done_seen;
    cur_cpol = 1'b0; cur_cpha = 1'b0; slave_lsb = 1'b0; slave_word = 8'h0F;
    for (int k = 0; k < 8; k++) exp_q.push_back(k < 4);
    @(negedge pclk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    baud_div = 8'd1; c2t_delay = 8'd1; t2c_delay = 8'd1;
    tx_data = 8'hF0; start = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge pclk);
      #2;
      if (m_edges == 4 && cs[0] === 1'b0) begin found = 1; break; end
    end
    compared++;
    if (!found) begin mismatched++; $display("FAIL rst_mid_reach_edge4: got timeout expected 4 edges"); end
    aborting = 1'b1;
    @(negedge pclk);
    areset = 1'b0;
    @(posedge pclk);
    #1;
    compared++;
    if (cs !== 1'b1 || sclk !== 1'b0 || mosi0 !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_pins: cs %b sclk %b mosi %b expected 1 0 0", cs, sclk, mosi0);
    end
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_status: busy %b done %b expected 0 0", busy, done);
    end
    compared++;
    if (rx_data !== 8'h00) begin mismatched++; $display("FAIL rst_mid_rx: got %h expected 00", rx_data); end
    @(negedge pclk);
    areset = 1'b1;
    exp_q.delete();
    done_seen = 0;
    repeat (40) begin
      @(posedge pclk);
      #1;
      if (done === 1'b1) done_seen = 1;
    end
    compared++;
    if (done_seen) begin mismatched++; $display("FAIL rst_mid_no_done: got done expected none"); end
    aborting = 1'b0;
    run_xfer(1'b1, 1'b1, 1'b0, 8'd2, 8'd3, 8'd2, 8'h5C, 8'hA9, lat);
    compared++;
    if (lat != 1 + 3 + 48 + 2) begin mismatched++; $display("FAIL rst_mid_latency: got %0d expected 54", lat); end
    compared++;
    if (rx_data !== 8'hA9) begin mismatched++; $display("FAIL rst_mid_rx_after: got %h expected a9", rx_data); end
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL rst_mid_bits_left: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_delays();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
